// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing helpers for the pipelined LUT neuron layer.
package lut_neuron_pkg;

    // Layer controller states: zero-fill all tables, then serve samples.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Default layer geometry.
    localparam int unsigned DEF_N_NEURONS = 4;
    localparam int unsigned DEF_IN_BITS   = 7;
    localparam int unsigned DEF_OUT_BITS  = 2;

    // Number of entries in one neuron truth table.
    function automatic int unsigned tbl_depth(input int unsigned in_bits);
        return 32'd1 << in_bits;
    endfunction

    // Neuron-select width; a single-neuron layer still gets a 1-bit index.
    function automatic int unsigned neuron_idx_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/lut_neuron_layer_pipe_if.sv
// Config, input-stream and output-stream signals of the LUT neuron layer.
interface lut_neuron_layer_pipe_if #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned IN_BITS   = 7,
    parameter int unsigned OUT_BITS  = 2
);
    import lut_neuron_pkg::*;

    localparam int unsigned IDX_W = neuron_idx_w(N_NEURONS);

    // Table write port.
    logic                          cfg_we;
    logic                          cfg_ready;
    logic [IDX_W-1:0]              cfg_neuron;
    logic [IN_BITS-1:0]            cfg_addr;
    logic [OUT_BITS-1:0]           cfg_data;

    // Input sample stream.
    logic                          s_valid;
    logic                          s_ready;
    logic [N_NEURONS*IN_BITS-1:0]  s_data;

    // Output sample stream.
    logic                          m_valid;
    logic                          m_ready;
    logic [N_NEURONS*OUT_BITS-1:0] m_data;

    // Upstream/downstream environment side.
    modport master (
        output cfg_we, cfg_neuron, cfg_addr, cfg_data,
        output s_valid, s_data,
        output m_ready,
        input  cfg_ready, s_ready, m_valid, m_data
    );

    // Layer side.
    modport slave (
        input  cfg_we, cfg_neuron, cfg_addr, cfg_data,
        input  s_valid, s_data,
        input  m_ready,
        output cfg_ready, s_ready, m_valid, m_data
    );

endinterface

// File: rtl/lut_neuron_ram.sv
// One neuron truth table: synchronous write, asynchronous read, no reset.
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int unsigned IN_BITS  = 7,
    parameter int unsigned OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [IN_BITS-1:0]  i_waddr,
    input  logic [OUT_BITS-1:0] i_wdata,
    input  logic [IN_BITS-1:0]  i_raddr,
    output logic [OUT_BITS-1:0] o_rdata
);
    localparam int unsigned DEPTH = tbl_depth(IN_BITS);

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] r_mem [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lut_neuron_layer_pipe.sv
// Pipelined layer of runtime-writable truth-table neurons with valid/ready streams.
// S1 holds the accepted sample; S2 holds the looked-up codes presented downstream.
module lut_neuron_layer_pipe
    import lut_neuron_pkg::*;
#(
    parameter int unsigned N_NEURONS = DEF_N_NEURONS,
    parameter int unsigned IN_BITS   = DEF_IN_BITS,
    parameter int unsigned OUT_BITS  = DEF_OUT_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    lut_neuron_layer_pipe_if.slave        bus,
    output logic                          init_done
);
    localparam int unsigned DEPTH        = tbl_depth(IN_BITS);
    localparam int unsigned NEURON_IDX_W = neuron_idx_w(N_NEURONS);
    localparam int unsigned S_W          = N_NEURONS * IN_BITS;
    localparam int unsigned M_W          = N_NEURONS * OUT_BITS;
    localparam logic [IN_BITS:0] CLR_LAST = (IN_BITS + 1)'(DEPTH - 1);
    localparam logic [IN_BITS:0] CLR_ONE  = (IN_BITS + 1)'(1);

    state_e               r_state;
    state_e               w_state_d;
    logic [IN_BITS:0]     r_clr_addr;
    logic [IN_BITS:0]     w_clr_addr_d;

    logic                 r_s1_valid;
    logic [S_W-1:0]       r_s1_data;
    logic                 r_m_valid;
    logic [M_W-1:0]       r_m_data;

    logic                 w_run;
    logic                 w_cfg_ready;
    logic                 w_cfg_fire;
    logic                 w_advance;
    logic                 w_s_ready;
    logic                 w_s_fire;

    logic [N_NEURONS-1:0] w_we;
    logic [IN_BITS-1:0]   w_waddr;
    logic [OUT_BITS-1:0]  w_wdata;
    logic [M_W-1:0]       w_lut;

    // Controller state and clear-sweep address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_d;
            r_clr_addr <= w_clr_addr_d;
        end
    end

    // Sweep every table entry exactly once, then park in RUN.
    always_comb begin
        w_state_d    = r_state;
        w_clr_addr_d = r_clr_addr;
        unique case (r_state)
            CLEAR: begin
                w_clr_addr_d = r_clr_addr + CLR_ONE;
                if (r_clr_addr == CLR_LAST) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                w_state_d = RUN;
            end
        endcase
    end

    assign w_run       = (r_state == RUN);
    // Writes only with S1 empty so a lookup never straddles a table change.
    assign w_cfg_ready = w_run && !r_s1_valid;
    assign w_cfg_fire  = bus.cfg_we && w_cfg_ready;
    assign w_advance   = !r_m_valid || bus.m_ready;
    // A config write wins over a simultaneous sample.
    assign w_s_ready   = w_run && !w_cfg_fire && (!r_s1_valid || w_advance);
    assign w_s_fire    = bus.s_valid && w_s_ready;

    // Shared write port: zero-fill during CLEAR, addressed config write in RUN.
    always_comb begin
        w_we    = '0;
        w_waddr = bus.cfg_addr;
        w_wdata = bus.cfg_data;
        if (!w_run) begin
            w_we    = '1;
            w_waddr = r_clr_addr[IN_BITS-1:0];
            w_wdata = '0;
        end else begin
            // Out-of-range indices match no neuron, so such writes are dropped.
            for (int i = 0; i < N_NEURONS; i++) begin
                if (w_cfg_fire && (bus.cfg_neuron == NEURON_IDX_W'(i))) begin
                    w_we[i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
        lut_neuron_ram #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_we[g]),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (r_s1_data[g*IN_BITS +: IN_BITS]),
            .o_rdata (w_lut[g*OUT_BITS +: OUT_BITS])
        );
    end

    // S1: capture accepted samples; empties when S2 takes its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_s_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= bus.s_data;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: register the lookup result; frozen while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_advance) begin
            r_m_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_m_data <= w_lut;
            end
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_data    = r_m_data;
    assign init_done     = w_run;

endmodule
